bus_copy_master: RTL and testbench

Bus initiator that copies a block of 32-bit words from one address range to another over the system bus. It drives the request side of the standard responder protocol (addr / w_rb / acc / wdata / req in, rdata / resp / fault back), one outstanding access at a time. It sits between a control source (CPU-side config registers or a test harness) and the bus interconnect, giving the design a hardware memory-to-peripheral and memory-to-memory mover.

---
 rtl/bus_copy_master_if.sv | 35 +++
 rtl/bus_copy_master.sv | 180 ++++++++++++++++++
 tb/tb_bus_copy_master.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_copy_master_if.sv
// Request/response bus between the copy engine (master) and the interconnect.
// Combinational wiring only; no storage, no added latency.
// One outstanding access: master raises req for one cycle and waits for resp.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

interface bus_copy_master_if #(
  parameter int AW = 32
);
  logic [AW-1:0]             bus_addr;
  logic                      bus_w_rb;
  logic [`BUS_ACC_WIDTH-1:0] bus_acc;
  logic [`BUS_WIDTH-1:0]     bus_wdata;
  logic                      bus_req;
  logic [`BUS_WIDTH-1:0]     bus_rdata;
  logic                      bus_resp;
  logic                      bus_fault;

  modport master (
    output bus_addr, bus_w_rb, bus_acc, bus_wdata, bus_req,
    input  bus_rdata, bus_resp, bus_fault
  );

  modport slave (
    input  bus_addr, bus_w_rb, bus_acc, bus_wdata, bus_req,
    output bus_rdata, bus_resp, bus_fault
  );
endinterface

// File: rtl/bus_copy_master.sv
// Block copy engine: reads a word at src, writes it at dst, repeats len times.
// start->first req 1 cycle; 4 cycles per word with a 1-cycle responder.
// Waits on bus_resp per access (optional timeout); start ignored while busy.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module bus_copy_master #(
  parameter int AW      = 32,
  parameter int LW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW-1:0] err_addr,
  bus_copy_master_if.master bus
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          src_q, src_d;
  logic [AW-1:0]          dst_q, dst_d;
  logic [LW-1:0]          cnt_q, cnt_d;
  logic [`BUS_WIDTH-1:0]  data_q, data_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [1:0]             err_code_q, err_code_d;
  logic [AW-1:0]          err_addr_q, err_addr_d;
  logic [TW-1:0]          tmo_nxt;
  logic                   tmo_hit;

  // Next-state logic: sequencing, pointer/count updates, timeout and error capture
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    tmo_d      = '0;          // cleared outside the wait states, so every wait starts at 0
    err_d      = err_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    tmo_nxt    = tmo_q + TW'(1);
    // Expiry once TIMEOUT cycles have been spent waiting; a resp in that same cycle wins
    tmo_hit    = (TIMEOUT != 0) && (tmo_nxt == TW'(TIMEOUT));

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d      = src;
          dst_d      = dst;
          cnt_d      = len;
          err_d      = 1'b0;
          err_code_d = 2'd0;
          err_addr_d = '0;
          state_d    = (len == '0) ? FIN : RD_REQ;
        end
      end
      RD_REQ: begin
        if (bus.bus_fault) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          err_addr_d = src_q;
          state_d    = FIN;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.bus_resp) begin
          data_d  = bus.bus_rdata;
          state_d = WR_REQ;
        end else if (tmo_hit) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          err_addr_d = src_q;
          state_d    = FIN;
        end else begin
          tmo_d = tmo_nxt;
        end
      end
      WR_REQ: begin
        if (bus.bus_fault) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          err_addr_d = dst_q;
          state_d    = FIN;
        end else begin
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (bus.bus_resp) begin
          src_d   = src_q + AW'(4);
          dst_d   = dst_q + AW'(4);
          cnt_d   = cnt_q - LW'(1);
          state_d = (cnt_q == LW'(1)) ? FIN : RD_REQ;
        end else if (tmo_hit) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          err_addr_d = dst_q;
          state_d    = FIN;
        end else begin
          tmo_d = tmo_nxt;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // State and datapath registers; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      tmo_q      <= tmo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Bus request side decodes from registered state only, so reset drops req at once
  always_comb begin
    bus.bus_req   = (state_q == RD_REQ) || (state_q == WR_REQ);
    bus.bus_w_rb  = (state_q == WR_REQ) || (state_q == WR_WAIT);
    bus.bus_addr  = bus.bus_w_rb ? dst_q : src_q;
    bus.bus_wdata = data_q;
    bus.bus_acc   = `BUS_ACC_4B;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_bus_copy_master.sv
// Testbench for bus_copy_master: directed table, reset/ignored-start sequence, random copies.
// Responder answers each accepted access after a per-access latency from lat_q.
// Reference model predicts access list, error outcome and done cycle from the copy rules.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tb_bus_copy_master;
  localparam int TMO = 4;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [31:0] src_i, dst_i;
  logic [15:0] len_i;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [31:0] err_addr;

  bus_copy_master_if #(.AW(32)) bus ();

  bus_copy_master #(.AW(32), .LW(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .src(src_i), .dst(dst_i), .len(len_i),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .err_addr(err_addr),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- responder / memory ----------------
  logic [31:0] mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  int          lat_q[$];
  int          fault_idx = -1;
  int          acc_k = 0;
  bit          pend = 0;
  int          pend_left = 0;
  bit          pend_wr = 0;
  logic [31:0] pend_addr = 0;
  logic        log_wr[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_dat[$];
  logic        exp_wr[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_dat[$];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  initial begin
    bus.bus_resp  = 1'b0;
    bus.bus_fault = 1'b0;
    bus.bus_rdata = '0;
  end

  always @(negedge clk) begin
    int lat;
    bus.bus_resp  = 1'b0;
    bus.bus_fault = 1'b0;
    bus.bus_rdata = '0;
    if (!rstn) begin
      pend = 0;
    end else begin
      if (pend) begin
        pend_left--;
        if (pend_left == 0) begin
          pend = 0;
          bus.bus_resp = 1'b1;
          if (!pend_wr) bus.bus_rdata = mem.exists(pend_addr) ? mem[pend_addr] : dflt(pend_addr);
        end
      end
      if (bus.bus_req) begin
        log_wr.push_back(bus.bus_w_rb);
        log_addr.push_back(bus.bus_addr);
        log_dat.push_back(bus.bus_w_rb ? bus.bus_wdata : 32'h0);
        if (acc_k == fault_idx) begin
          bus.bus_fault = 1'b1;
        end else begin
          lat = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
          if (bus.bus_w_rb) mem[bus.bus_addr] = bus.bus_wdata;
          if (lat <= 50) begin
            pend = 1; pend_left = lat; pend_wr = bus.bus_w_rb; pend_addr = bus.bus_addr;
          end
        end
        acc_k++;
      end
    end
  end

  // ---------------- reference model ----------------
  // Walk words in ascending order, read then write; each access costs one req cycle
  // plus its wait; a fault ends at the req, a wait beyond TMO ends after TMO cycles.
  task automatic model(input logic [31:0] s, d, input int n, input int fidx,
                       output int e_done, output logic e_err, output logic [1:0] e_code,
                       output logic [31:0] e_ea);
    int lq[$];
    int k = 0;
    int lat;
    bit stop = 0;
    logic [31:0] a, word;
    lq = lat_q;
    model_mem = mem;
    exp_wr.delete(); exp_addr.delete(); exp_dat.delete();
    e_done = 1; e_err = 0; e_code = 0; e_ea = 0; word = 0;
    for (int i = 0; i < n && !stop; i++) begin
      for (int ph = 0; ph < 2 && !stop; ph++) begin
        a = (ph == 0) ? s + 32'(4 * i) : d + 32'(4 * i);
        exp_wr.push_back(ph == 1);
        exp_addr.push_back(a);
        exp_dat.push_back((ph == 1) ? word : 32'h0);
        if (k == fidx) begin
          stop = 1; e_err = 1; e_code = (ph == 0) ? 2'd1 : 2'd2; e_ea = a; e_done += 1;
        end else begin
          lat = (lq.size() != 0) ? lq.pop_front() : 1;
          if (ph == 1) model_mem[a] = word;
          if (lat > TMO) begin
            stop = 1; e_err = 1; e_code = 2'd3; e_ea = a; e_done += 1 + TMO;
          end else begin
            e_done += 1 + lat;
            if (ph == 0) word = model_mem.exists(a) ? model_mem[a] : dflt(a);
          end
        end
        k++;
      end
    end
  endtask

  // ---------------- one transfer ----------------
  task automatic run_xfer(input logic [31:0] s, d, input int n, input int fidx,
                          output int a_done, output logic a_err, output logic [1:0] a_code,
                          output logic [31:0] a_ea, output int a_nacc);
    int e_done; logic e_err; logic [1:0] e_code; logic [31:0] e_ea;
    int c;
    model(s, d, n, fidx, e_done, e_err, e_code, e_ea);
    @(negedge clk);
    log_wr.delete(); log_addr.delete(); log_dat.delete();
    acc_k = 0; fault_idx = fidx;
    src_i = s; dst_i = d; len_i = 16'(n); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 400);
    a_done = c; a_err = err; a_code = err_code; a_ea = err_addr;
    chk("done_cycle", 80'(c), 80'(e_done));
    chk("busy_at_done", 80'(busy), 80'(1));
    chk("err", 80'(err), 80'(e_err));
    chk("err_code", 80'(err_code), 80'(e_code));
    chk("err_addr", 80'(err_addr), 80'(e_ea));
    @(negedge clk);
    chk("busy_after_done", 80'(busy), 80'(0));
    chk("done_one_cycle", 80'(done), 80'(0));
    chk("err_sticky", 80'(err), 80'(e_err));
    a_nacc = log_addr.size();
    chk("access_count", 80'(a_nacc), 80'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < a_nacc; i++)
      chk($sformatf("access%0d", i), {15'b0, log_wr[i], log_addr[i], log_dat[i]},
          {15'b0, exp_wr[i], exp_addr[i], exp_dat[i]});
    c = 0;
    while (pend && c < 50) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          fidx;
    int          rd_lat;
    int          done_cyc;
    logic        err;
    logic [1:0]  code;
    logic [31:0] eaddr;
    int          nacc;
  } vec_t;

  vec_t vt[7];

  initial begin
    int a_done, a_nacc, c;
    logic a_err;
    logic [1:0] a_code;
    logic [31:0] a_ea, s, d;
    int n, fidx;

    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (limit 1000000 ns)");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_done, a_nacc, c, n, fidx;
    logic a_err;
    logic [1:0] a_code;
    logic [31:0] a_ea, s, d;
    logic [31:0] expw [3];

    vt[0] = '{32'h100, 32'h200, 3, -1, 1, 13, 1'b0, 2'd0, 32'h0, 6};
    vt[1] = '{32'h100, 32'h200, 0, -1, 1, 1, 1'b0, 2'd0, 32'h0, 0};
    vt[2] = '{32'h100, 32'h200, 3, 3, 1, 8, 1'b1, 2'd2, 32'h204, 4};
    vt[3] = '{32'h100, 32'h200, 2, -1, 99, 6, 1'b1, 2'd3, 32'h100, 1};
    vt[4] = '{32'hFFFF_FFFC, 32'h300, 2, -1, 1, 9, 1'b0, 2'd0, 32'h0, 4};
    vt[5] = '{32'h100, 32'h200, 2, 0, 1, 2, 1'b1, 2'd1, 32'h100, 1};
    vt[6] = '{32'h500, 32'h600, 1, -1, 4, 8, 1'b0, 2'd0, 32'h0, 2};
    expw[0] = 32'hA0A0_0001; expw[1] = 32'hA0A0_0002; expw[2] = 32'hA0A0_0003;

    rstn = 1'b0; start = 1'b0; src_i = 0; dst_i = 0; len_i = 0;
    mem[32'h100] = 32'hA0A0_0001;
    mem[32'h104] = 32'hA0A0_0002;
    mem[32'h108] = 32'hA0A0_0003;
    repeat (3) @(negedge clk);
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_done", 80'(done), 80'(0));
    chk("rst_err", 80'({err, err_code, err_addr}), 80'(0));
    chk("rst_bus", 80'({bus.bus_req, bus.bus_w_rb, bus.bus_addr, bus.bus_wdata}), 80'(0));
    chk("rst_acc", 80'(bus.bus_acc), 80'(`BUS_ACC_4B));
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      lat_q.delete();
      for (int w = 0; w < vt[i].len; w++) begin
        lat_q.push_back(vt[i].rd_lat);
        lat_q.push_back(1);
      end
      run_xfer(vt[i].src, vt[i].dst, vt[i].len, vt[i].fidx, a_done, a_err, a_code, a_ea, a_nacc);
      chk($sformatf("vec%0d_done", i), 80'(a_done), 80'(vt[i].done_cyc));
      chk($sformatf("vec%0d_err", i), 80'({a_err, a_code, a_ea}),
          80'({vt[i].err, vt[i].code, vt[i].eaddr}));
      chk($sformatf("vec%0d_nacc", i), 80'(a_nacc), 80'(vt[i].nacc));
      if (i == 0 && a_nacc == 6)
        for (int j = 0; j < 3; j++) begin
          chk($sformatf("vec0_rd%0d_addr", j), 80'(log_addr[2*j]), 80'(32'h100 + 32'(4*j)));
          chk($sformatf("vec0_wr%0d", j), 80'({log_addr[2*j+1], log_dat[2*j+1]}),
              80'({32'h200 + 32'(4*j), expw[j]}));
        end
      if (i == 4 && a_nacc > 2)
        chk("vec4_wrap_addr", 80'(log_addr[2]), 80'(0));
    end

    // start while busy is ignored; reset in the second WR_WAIT abandons the copy
    lat_q.delete();
    @(negedge clk);
    log_wr.delete(); log_addr.delete(); log_dat.delete();
    acc_k = 0; fault_idx = -1;
    src_i = 32'h400; dst_i = 32'h600; len_i = 16'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    src_i = 32'h800; dst_i = 32'h900; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0; n = 0;
    while (n < 2 && c < 60) begin
      @(negedge clk);
      c++;
      if (busy && bus.bus_w_rb && !bus.bus_req) n++;
    end
    chk("reached_wr_wait", 80'(n), 80'(2));
    chk("ignored_start_rd1", 80'(log_addr.size() > 2 ? log_addr[2] : 32'hDEAD), 80'(32'h404));
    chk("ignored_start_wr1", 80'(log_addr.size() > 3 ? log_addr[3] : 32'hDEAD), 80'(32'h604));
    #2 rstn = 1'b0;
    #1;
    chk("midrst_req", 80'(bus.bus_req), 80'(0));
    chk("midrst_state", 80'({busy, done, err, err_code, err_addr}), 80'(0));
    chk("midrst_bus", 80'({bus.bus_w_rb, bus.bus_addr, bus.bus_wdata}), 80'(0));
    c = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) c++;
    end
    chk("midrst_no_done", 80'(c), 80'(0));
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    lat_q.delete();
    run_xfer(32'h1000, 32'h2000, 2, -1, a_done, a_err, a_code, a_ea, a_nacc);
    chk("post_rst_done", 80'(a_done), 80'(9));

    // randomized copies: latency, faults, timeouts, overlap and wrap
    for (int r = 0; r < 40; r++) begin
      s = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) s = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
      d = ($urandom_range(0, 2) == 0) ? s + 32'($urandom_range(0, 3)) * 4 : ($urandom & 32'hFFFF_FFFC);
      n = $urandom_range(0, 5);
      for (int w = 0; w < n; w++) mem[s + 32'(4*w)] = $urandom;
      lat_q.delete();
      for (int w = 0; w < 2 * n; w++)
        lat_q.push_back(($urandom_range(0, 9) == 0) ? TMO + 1 : int'($urandom_range(1, TMO)));
      fidx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2 * n)) : -1;
      run_xfer(s, d, n, fidx, a_done, a_err, a_code, a_ea, a_nacc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
